// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared types and constants for the sprite-engine commit controller
package ppu_pkg;

  typedef struct packed {
    logic       enable;
    logic [6:0] rsvd;
    logic [3:0] frame;
    logic [9:0] y;
    logic [9:0] x;
  } sprite_t;

  localparam logic [3:0] ADDR_BG     = 4'd8;
  localparam logic [3:0] ADDR_CTRL   = 4'd9;
  localparam logic [3:0] ADDR_STATUS = 4'd10;

  localparam int CTRL_COMMIT  = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_IRQ_ACK = 2;

  typedef enum logic [1:0] {IDLE, PENDING, COMMIT, DONE} state_t;

  localparam logic [23:0] BG_RESET = 24'h000080;

endpackage

// File: rtl/ppu_vblank_detect.sv
// rtl/ppu_vblank_detect.sv - one-cycle registered pulse when line VACTIVE starts
module ppu_vblank_detect #(
  parameter int VACTIVE = 480
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  output logic        vblank
);

  logic hit;
  logic hit_q;

  assign hit = (hcount == 11'd0) && (vcount == 10'(VACTIVE));

  // Edge-detect so a pixel clock slower than clk (hcount held several cycles) still yields one pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_q  <= 1'b0;
      vblank <= 1'b0;
    end else begin
      hit_q  <= hit;
      vblank <= hit && !hit_q;
    end
  end

endmodule

// File: rtl/ppu_commit_ctrl.sv
// rtl/ppu_commit_ctrl.sv - shadow/active register set with vblank-aligned commit
// Optional PPU_AUTO_COMMIT_EN: any accepted shadow write requests a commit implicitly.
module ppu_commit_ctrl
  import ppu_pkg::*;
#(
  parameter int NSPRITES = 4,
  parameter int VACTIVE  = 480
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  chipselect,
  input  logic                  write,
  input  logic                  read,
  input  logic [3:0]            address,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic                  waitrequest,
  input  logic [10:0]           hcount,
  input  logic [9:0]            vcount,
  output logic [NSPRITES*32-1:0] active_sprites,
  output logic [23:0]           active_bg,
  output logic [15:0]           frame_count,
  output logic                  irq
);

  localparam logic [3:0] LAST_IDX = 4'(NSPRITES);

  sprite_t     shadow_spr [NSPRITES];
  sprite_t     active_spr [NSPRITES];
  logic [23:0] shadow_bg;
  logic [23:0] active_bg_q;
  state_t      state, state_nx;
  logic [3:0]  idx;
  logic        irq_en, irq_q, req_seen, vblank;
  logic        is_spr, is_bg, shadow_sel, shadow_wr, ctrl_wr, commit_req, req_any;
  logic        pending, busy;
  logic [31:0] rd_mux;

  ppu_vblank_detect #(.VACTIVE(VACTIVE)) u_vblank (
    .clk     (clk),
    .reset_n (reset_n),
    .hcount  (hcount),
    .vcount  (vcount),
    .vblank  (vblank)
  );

  assign is_spr      = address < LAST_IDX;
  assign is_bg       = address == ADDR_BG;
  assign shadow_sel  = chipselect && write && (is_spr || is_bg);
  assign waitrequest = shadow_sel && (state == COMMIT);
  assign shadow_wr   = shadow_sel && !waitrequest;
  assign ctrl_wr     = chipselect && write && (address == ADDR_CTRL);
  assign commit_req  = ctrl_wr && writedata[CTRL_COMMIT];

`ifdef PPU_AUTO_COMMIT_EN
  logic dirty;
  assign req_any = commit_req || dirty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                       dirty <= 1'b0;
    else if (state == PENDING && vblank) dirty <= 1'b0;
    else if (shadow_wr)                 dirty <= 1'b1;
  end
`else
  assign req_any = commit_req;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_any) state_nx = PENDING;
      PENDING: if (vblank) state_nx = COMMIT;
      COMMIT:  if (idx == LAST_IDX) state_nx = DONE;
      DONE:    state_nx = (req_seen || req_any) ? PENDING : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      idx      <= 4'd0;
      req_seen <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == PENDING && vblank) idx <= 4'd0;
      else if (state == COMMIT)       idx <= idx + 4'd1;
      // A request landing mid-copy must survive until DONE decides where to go.
      if (state == COMMIT && commit_req) req_seen <= 1'b1;
      else if (state == DONE)            req_seen <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NSPRITES; i++) shadow_spr[i] <= '0;
      shadow_bg <= BG_RESET;
    end else if (shadow_wr) begin
      for (int i = 0; i < NSPRITES; i++)
        if (address == 4'(i)) shadow_spr[i] <= sprite_t'(writedata);
      if (is_bg) shadow_bg <= writedata[23:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NSPRITES; i++) active_spr[i] <= '0;
      active_bg_q <= BG_RESET;
    end else if (state == COMMIT) begin
      for (int i = 0; i < NSPRITES; i++)
        if (idx == 4'(i)) active_spr[i] <= shadow_spr[i];
      if (idx == LAST_IDX) active_bg_q <= shadow_bg;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en      <= 1'b0;
      irq_q       <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      if (ctrl_wr) irq_en <= writedata[CTRL_IRQ_EN];
      if (state == DONE && irq_en)               irq_q <= 1'b1;
      else if (ctrl_wr && writedata[CTRL_IRQ_ACK]) irq_q <= 1'b0;
      if (vblank) frame_count <= frame_count + 16'd1;
    end
  end

  assign pending = (state == PENDING) || req_seen;
  assign busy    = (state == COMMIT) || (state == DONE);

  always_comb begin
    rd_mux = '0;
    if (is_spr) begin
      for (int i = 0; i < NSPRITES; i++)
        if (address == 4'(i)) rd_mux = shadow_spr[i];
    end else if (is_bg) begin
      rd_mux = {8'h00, shadow_bg};
    end else if (address == ADDR_STATUS) begin
      rd_mux = {frame_count, 13'd0, irq_q, pending, busy};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                readdata <= '0;
    else if (chipselect && read) readdata <= rd_mux;
  end

  for (genvar g = 0; g < NSPRITES; g++) begin : g_flat
    assign active_sprites[32*g +: 32] = active_spr[g];
  end

  assign active_bg = active_bg_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_ppu_commit_ctrl.sv
// tb/tb_ppu_commit_ctrl.sv - directed self-checking bench for ppu_commit_ctrl
module tb_ppu_commit_ctrl;

  localparam int NSPR = 4;
  localparam int VACT = 6;
  localparam int HTOT = 8;
  localparam int VTOT = 8;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 chipselect = 1'b0;
  logic                 write = 1'b0;
  logic                 read = 1'b0;
  logic [3:0]           address = 4'd0;
  logic [31:0]          writedata = 32'd0;
  logic [31:0]          readdata;
  logic                 waitrequest;
  logic [10:0]          hcount;
  logic [9:0]           vcount;
  logic [NSPR*32-1:0]   active_sprites;
  logic [23:0]          active_bg;
  logic [15:0]          frame_count;
  logic                 irq;

  int          checks = 0;
  int          failures = 0;
  int          exp_fc = 0;
  int          waits;
  logic        found;
  logic [31:0] exp_q[$];
  logic [31:0] mspr [NSPR];
  logic [31:0] mact [NSPR];
  logic [23:0] mbg_act;

  ppu_commit_ctrl #(.NSPRITES(NSPR), .VACTIVE(VACT)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .chipselect     (chipselect),
    .write          (write),
    .read           (read),
    .address        (address),
    .writedata      (writedata),
    .readdata       (readdata),
    .waitrequest    (waitrequest),
    .hcount         (hcount),
    .vcount         (vcount),
    .active_sprites (active_sprites),
    .active_bg      (active_bg),
    .frame_count    (frame_count),
    .irq            (irq)
  );

  always #10 clk = ~clk;

  // Shrunken raster: HTOT pixels per line, VTOT lines per frame, updated away from the sampling edge.
  initial begin
    hcount = 11'd0;
    vcount = 10'd0;
    forever begin
      @(negedge clk);
      if (hcount == 11'(HTOT - 1)) begin
        hcount = 11'd0;
        vcount = (vcount == 10'(VTOT - 1)) ? 10'd0 : vcount + 10'd1;
      end else begin
        hcount = hcount + 11'd1;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, output int n);
    logic w;
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      w = waitrequest;
      tick();
      if (!w) break;
      n++;
    end
    chipselect = 1'b0; write = 1'b0;
    if (n >= 40) begin
      failures++;
      $error("FAIL wr_bound observed=%0d expected=<40", n);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    int n;
    bus_write(a, d, n);
  endtask

  task automatic bus_read(input logic [3:0] a, input logic [31:0] exp, input string tag);
    chipselect = 1'b1; read = 1'b1; address = a;
    exp_q.push_back(exp);
    tick();
    chipselect = 1'b0; read = 1'b0;
    check(tag, readdata, exp_q.pop_front());
  endtask

  task automatic wait_fc(input string tag);
    exp_fc++;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (frame_count == 16'(exp_fc)) break;
    end
    check(tag, {16'd0, frame_count}, 32'(exp_fc));
  endtask

  task automatic check_active(input string tag);
    for (int i = 0; i < NSPR; i++)
      check($sformatf("%s_s%0d", tag, i), active_sprites[32*i +: 32], mact[i]);
    check({tag, "_bg"}, {8'd0, active_bg}, {8'd0, mbg_act});
  endtask

  task automatic snapshot;
    for (int i = 0; i < NSPR; i++) mact[i] = mspr[i];
  endtask

  initial begin
    for (int i = 0; i < NSPR; i++) begin mspr[i] = 32'd0; mact[i] = 32'd0; end
    mbg_act = 24'h000080;

    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    check_active("rst");
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_fc", {16'd0, frame_count}, 32'd0);
    check("rst_wait", {31'd0, waitrequest}, 32'd0);
    check("rst_rdata", readdata, 32'd0);
    bus_read(4'd8, 32'h0000_0080, "rd_bg_rst");
    wait_fc("fc1");
    wait_fc("fc2");

    wr(4'd1, 32'h8015_0C8A); mspr[1] = 32'h8015_0C8A;
    wr(4'd9, 32'h3);
    bus_read(4'd1, mspr[1], "t2_rd_spr1");
    bus_read(4'd10, {16'(exp_fc), 16'h0002}, "t2_status_pend");
    check("t2_pre_slot1", active_sprites[63:32], 32'd0);
    wait_fc("t2_fc3");
    check("t2_at_pulse", active_sprites[63:32], 32'd0);
    tick(); tick();
    check("t2_slot1", active_sprites[63:32], 32'h8015_0C8A);
    repeat (3) tick();
    check("t2_irq_in_done", {31'd0, irq}, 32'd0);
    tick();
    check("t2_irq", {31'd0, irq}, 32'd1);
    snapshot();
    check_active("t2_act");
    bus_read(4'd10, {16'(exp_fc), 16'h0004}, "t2_status_done");
    wr(4'd9, 32'h6);
    check("t2_ack", {31'd0, irq}, 32'd0);

    wr(4'd2, 32'h1234_5678); mspr[2] = 32'h1234_5678;
    wr(4'd9, 32'h3);
    wait_fc("t3_fc4");
    snapshot();
    bus_write(4'd0, 32'hDEAD_BEEF, waits);
    mspr[0] = 32'hDEAD_BEEF;
    check("t3_waits", 32'(waits), 32'(NSPR + 1));
    check_active("t3_act");
    check("t3_irq", {31'd0, irq}, 32'd1);
    bus_read(4'd0, 32'hDEAD_BEEF, "t3_rd0");
    wr(4'd9, 32'h6);
    check("t3_ack", {31'd0, irq}, 32'd0);
`ifdef PPU_AUTO_COMMIT_EN
    wait_fc("t3_auto_fc");
    repeat (7) tick();
    snapshot();
    check_active("t3_auto");
    wr(4'd9, 32'h6);
`endif

    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (hcount == 11'd0 && vcount == 10'(VACT)) begin found = 1'b1; break; end
    end
    check("t4_hit_found", {31'd0, found}, 32'd1);
    wr(4'd9, 32'h3);
    exp_fc++;
    check("t4_fc_pulse", {16'd0, frame_count}, 32'(exp_fc));
    repeat (8) tick();
    check("t4_no_commit", {31'd0, irq}, 32'd0);
    bus_read(4'd10, {16'(exp_fc), 16'h0002}, "t4_status_pend");
    wait_fc("t4_fc_next");
    repeat (5) tick();
    check("t5_pre", {31'd0, irq}, 32'd0);
    wr(4'd9, 32'h6);
    check("t5_set_wins", {31'd0, irq}, 32'd1);
    wr(4'd9, 32'h6);
    check("t5_ack", {31'd0, irq}, 32'd0);
    snapshot();
    check_active("t5_act");

    wr(4'd8, 32'h0000_FF00);
    bus_read(4'd8, 32'h0000_FF00, "t6_rd_bg");
    wait_fc("t6_fc");
    repeat (7) tick();
`ifdef PPU_AUTO_COMMIT_EN
    check("t6_auto_bg", {8'd0, active_bg}, 32'h0000_FF00);
`else
    check("t6_bg_held", {8'd0, active_bg}, 32'h0000_0080);
`endif

    wr(4'd11, 32'hFFFF_FFFF);
    wr(4'd4, 32'hFFFF_FFFF);
    bus_read(4'd11, 32'd0, "rd_unmapped");
    bus_read(4'd4, 32'd0, "rd_addr_nspr");
    bus_read(4'd9, 32'd0, "rd_ctrl");
    bus_read(4'd3, 32'd0, "rd_spr3");

    wr(4'd9, 32'h1);
    wait_fc("rst_mid_fc");
    tick(); tick();
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < NSPR; i++) mact[i] = 32'd0;
    mbg_act = 24'h000080;
    check_active("rst_mid");
    check("rst_mid_irq", {31'd0, irq}, 32'd0);
    check("rst_mid_fc", {16'd0, frame_count}, 32'd0);
    tick();
    reset_n = 1'b1;
    exp_fc = 0;
    tick();
    bus_read(4'd1, 32'd0, "rst_mid_shadow");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ppu_commit_ctrl.md
Name: ppu_commit_ctrl

Overview:
- Avalon-MM register front end and frame scheduler for the sprite engine's pixel datapath.
- CPU writes land in shadow registers for sprite and background state. On an explicit commit request, the block copies the shadow set into the active set at the start of vertical blank, so the pixel path never shows a torn frame.
- Sits between the bus slave port and the pixel-generation logic.
- Consumes hcount/vcount from the VGA counter block and raises a frame-done interrupt.

Parameters:
- NSPRITES, 4, number of sprite slots; legal range 1..8.
- VACTIVE, 480, first non-visible line; the vblank pulse fires when this line starts.

Ports:
- clk  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous active-low reset
- chipselect  in  1  Avalon slave select
- write  in  1  Avalon write strobe
- read  in  1  Avalon read strobe
- address  in  4  word address
- writedata  in  32  write data
- readdata  out  32  read data, valid the cycle after read
- waitrequest  out  1  stalls shadow writes during COMMIT
- hcount  in  11  from vga_counters
- vcount  in  10  from vga_counters
- active_sprites  out  NSPRITES*32  committed sprite words; slot i at [32i+31:32i]
- active_bg  out  24  committed background {r,g,b}
- frame_count  out  16  vblank counter
- irq  out  1  commit-done interrupt, level

Behaviour:
- Sprite word format: [9:0] x, [19:10] y, [23:20] frame, [31] enable; other bits are stored but ignored downstream.
- Address map:
  - 0..NSPRITES-1: shadow sprite words (R/W).
  - 8: shadow bg [23:0] (R/W).
  - 9: control, write-only. Bit0 commit_req, bit1 irq_en, bit2 irq_ack.
  - 10: status, read-only. {frame_count[15:0], 13'b0, irq, pending, busy}.
  - Unmapped: writes ignored, reads return 0.
- Reset values: all shadow and active sprites 0; bg shadow and active 24'h000080; frame_count 0; irq 0; irq_en 0; readdata 0; waitrequest 0; state IDLE.
- vblank pulse:
  - Registered, one cycle wide.
  - Asserted the cycle after hcount==0 && vcount==VACTIVE is sampled.
  - Exactly one pulse per frame.
- frame_count increments on every vblank pulse and wraps FFFF->0000.
- FSM states:
  - IDLE: a commit_req write moves to PENDING.
  - PENDING: on a vblank pulse, go to COMMIT with idx=0. Further commit_req writes have no extra effect.
  - COMMIT:
    - Each cycle copies shadow[idx] to active[idx] and increments idx.
    - When idx==NSPRITES, copies bg and goes to DONE.
    - Takes NSPRITES+1 cycles in total.
  - DONE (1 cycle): sets irq if irq_en=1. Goes to PENDING if a commit_req arrived during COMMIT/DONE, otherwise to IDLE.
- Request/pulse coincidence: a commit_req written in the same cycle as a vblank pulse while IDLE does not catch that pulse; it waits for the next frame.
- waitrequest:
  - Asserted combinationally when chipselect && write && state==COMMIT && address targets a sprite or bg word.
  - Control writes and all reads never stall.
  - The write completes on the first cycle waitrequest is low.
- Reads: readdata is registered with 1-cycle latency and returns the shadow values, not the active ones.
- irq:
  - irq_ack=1 clears irq.
  - If a set (DONE) and an ack occur in the same cycle, the set wins.
  - Clearing irq_en does not clear a pending irq.
- Reset mid-COMMIT: everything returns to reset values immediately. A partially copied active set is discarded to reset values.

Optional Feature:
- PPU_AUTO_COMMIT_EN defined:
  - Any accepted shadow sprite/bg write sets an internal dirty flag, which behaves as an implicit commit_req.
  - dirty clears on entry to COMMIT.
  - Writes during COMMIT/DONE re-set dirty.
- Undefined: only explicit commit_req triggers a commit; the dirty logic is absent.

Decomposition:
- Package ppu_pkg:
  - sprite_t packed struct (enable, frame, y, x).
  - Address constants ADDR_BG=8, ADDR_CTRL=9, ADDR_STATUS=10.
  - Control bit indices.
  - state_t enum {IDLE, PENDING, COMMIT, DONE}.
  - Reset bg constant 24'h000080.
- One sub-module, ppu_vblank_detect: hcount/vcount in, registered vblank pulse out.

Test Plan:
1. Release reset -> active_bg=000080, all active_sprites=0, irq=0, frame_count=0. Run 2 frames -> frame_count=2.
2. Write sprite1=0x8015_0C8A, write ctrl=0x3 -> active unchanged until the vblank pulse. Then active slot1=0x80150C8A after 2 cycles, irq=1 at DONE+1, status bit1 pending=0.
3. During COMMIT, write sprite0 -> waitrequest high until COMMIT/DONE exits. The value does not appear in active until the next commit.
4. commit_req written in the vblank-pulse cycle from IDLE -> commit occurs one frame later; frame_count advances by 2 before active changes.
5. irq_ack written in the DONE cycle -> irq=1 remains. A later ack -> irq=0.
6. With PPU_AUTO_COMMIT_EN, write bg=0x00FF00 with no ctrl write -> active_bg=00FF00 after the next vblank. Without the macro -> active_bg stays 000080.
